// File: rtl/axis_stream_in.sv
// AXI-Stream-like sink: registered s_ready, 2-deep skid buffer (head + skid), FIFO write side, frame tagging.
// Define AXIS_IN_STALL_CNT_EN to build the saturating stall-cycle counter; otherwise stall_cycles reads 0.
module axis_stream_in #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 256
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              enable,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic              fifo_wr_last,
  input  logic              fifo_full,
  output logic              frame_done,
  output logic [15:0]       frame_cnt,
  output logic [31:0]       stall_cycles
);

  localparam int               CNT_W    = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  logic              accept;
  logic              drain;
  logic              wr_last;
  logic              head_valid;
  logic              skid_valid;
  logic              head_valid_nxt;
  logic              skid_valid_nxt;
  logic [DATA_W-1:0] head_data;
  logic [DATA_W-1:0] skid_data;
  logic [DATA_W-1:0] head_data_nxt;
  logic [DATA_W-1:0] skid_data_nxt;
  logic [CNT_W-1:0]  word_cnt;

  assign accept       = s_valid && s_ready;
  assign drain        = enable && head_valid && !fifo_full;
  assign wr_last      = drain && (word_cnt == LAST_IDX);
  assign fifo_wr_en   = drain;
  assign fifo_wr_data = head_data;
  assign fifo_wr_last = wr_last;

  // Skid update: a word arriving while head drains with skid empty goes straight to head (no bubble).
  always_comb begin
    head_valid_nxt = head_valid;
    skid_valid_nxt = skid_valid;
    head_data_nxt  = head_data;
    skid_data_nxt  = skid_data;
    if (drain) begin
      if (skid_valid) begin
        head_data_nxt  = skid_data;
        skid_valid_nxt = 1'b0;
      end else begin
        head_valid_nxt = 1'b0;
      end
    end
    if (accept) begin
      if (!head_valid || (drain && !skid_valid)) begin
        head_data_nxt  = s_data;
        head_valid_nxt = 1'b1;
      end else begin
        skid_data_nxt  = s_data;
        skid_valid_nxt = 1'b1;
      end
    end
    if (!enable) begin
      head_valid_nxt = 1'b0;
      skid_valid_nxt = 1'b0;
    end
  end

  // Buffer / ready / frame stage
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
      head_data  <= '0;
      skid_data  <= '0;
      s_ready    <= 1'b0;
      word_cnt   <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      head_valid <= head_valid_nxt;
      skid_valid <= skid_valid_nxt;
      head_data  <= head_data_nxt;
      skid_data  <= skid_data_nxt;
      s_ready    <= enable && !skid_valid_nxt;
      frame_done <= wr_last;
      if (wr_last)
        frame_cnt <= frame_cnt + 16'd1;
      if (!enable)
        word_cnt <= '0;
      else if (drain)
        word_cnt <= wr_last ? '0 : word_cnt + CNT_W'(1);
    end
  end

`ifdef AXIS_IN_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      stall_q <= '0;
    else if (enable && head_valid && fifo_full && (stall_q != 32'hFFFF_FFFF))
      stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_axis_stream_in.sv
// Bench for axis_stream_in: directed steps plus a scoreboard fed from accepted words.
module tb_axis_stream_in;
  localparam int DATA_W = 16;
  localparam int FLEN   = 4;

  logic              sys_clk   = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              enable    = 1'b0;
  logic              s_valid   = 1'b0;
  logic              fifo_full = 1'b0;
  logic [DATA_W-1:0] s_data    = '0;
  logic              s_ready;
  logic              fifo_wr_en;
  logic              fifo_wr_last;
  logic              frame_done;
  logic [DATA_W-1:0] fifo_wr_data;
  logic [15:0]       frame_cnt;
  logic [31:0]       stall_cycles;

  int                n_chk = 0;
  int                n_err = 0;
  int                n_done = 0;
  int                m_cnt = 0;
  logic              exp_done = 1'b0;
  logic [15:0]       exp_fcnt = '0;
  logic [DATA_W-1:0] sb[$];
  logic              took;

  axis_stream_in #(.DATA_W(DATA_W), .FRAME_LEN(FLEN)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .enable       (enable),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_wr_last (fifo_wr_last),
    .fifo_full    (fifo_full),
    .frame_done   (frame_done),
    .frame_cnt    (frame_cnt),
    .stall_cycles (stall_cycles)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic fail(input string tag);
    n_err++;
    $error("FAIL %s", tag);
  endtask

  task automatic check(input string tag, input logic ok);
    n_chk++;
    if (ok !== 1'b1) fail(tag);
  endtask

  // Scoreboard: push on accept, pop and compare on each FIFO write
  always @(negedge sys_clk) begin
    logic [DATA_W-1:0] exp_d;
    if (!sys_rst_n) begin
      sb.delete();
      m_cnt    = 0;
      exp_done = 1'b0;
      exp_fcnt = '0;
    end else begin
      n_chk++;
      if (frame_done !== exp_done) fail("frame_done");
      n_chk++;
      if (frame_cnt !== exp_fcnt) fail("frame_cnt");
      n_chk++;
      if ((s_ready && dut.skid_valid) !== 1'b0) fail("ready_with_skid");
      if (frame_done) n_done++;
      exp_done = 1'b0;
      if (!enable || fifo_full) begin
        n_chk++;
        if (fifo_wr_en !== 1'b0) fail("wr_blocked");
      end
      if (!enable) begin
        sb.delete();
        m_cnt = 0;
      end else begin
        if (fifo_wr_en) begin
          if (sb.size() == 0) begin
            n_chk++;
            fail("wr_unexpected");
          end else begin
            exp_d = sb.pop_front();
            n_chk++;
            if (fifo_wr_data !== exp_d) fail("wr_data");
          end
          n_chk++;
          if (fifo_wr_last !== (m_cnt == FLEN - 1)) fail("wr_last");
          if (m_cnt == FLEN - 1) begin
            exp_done = 1'b1;
            exp_fcnt = exp_fcnt + 16'd1;
            m_cnt    = 0;
          end else begin
            m_cnt++;
          end
        end else begin
          n_chk++;
          if (fifo_wr_last !== 1'b0) fail("idle_last");
        end
        if (s_valid && s_ready) sb.push_back(s_data);
      end
    end
  end

  task automatic tick();
    @(negedge sys_clk);
    took = s_valid && s_ready;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic stream_cycle();
    tick();
    if (took) s_data = s_data + 16'd1;
  endtask

  initial begin
    int          acc;
    int          acc_full;
    int          cyc;
    int          done0;
    logic [15:0] fc0;
    logic [31:0] st0;

    // Reset state
    #12;
    @(negedge sys_clk);
    check("rst_s_ready", s_ready === 1'b0);
    check("rst_wr_en", fifo_wr_en === 1'b0);
    check("rst_wr_last", fifo_wr_last === 1'b0);
    check("rst_frame_done", frame_done === 1'b0);
    check("rst_frame_cnt", frame_cnt === 16'd0);
    check("rst_stall", stall_cycles === 32'd0);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;

    // Continuous burst 0x0001..0x0010
    @(posedge sys_clk); #1;
    enable  = 1'b1;
    s_valid = 1'b1;
    s_data  = 16'h0001;
    @(posedge sys_clk); #1;
    @(negedge sys_clk);
    check("ready_after_en", s_ready === 1'b1);
    for (int k = 1; k <= 16; k++) begin
      @(posedge sys_clk); #1;
      s_data = 16'(k + 1);
      if (k == 16) s_valid = 1'b0;
      @(negedge sys_clk);
      check("burst_wr_en", fifo_wr_en === 1'b1);
      check("burst_data", fifo_wr_data === 16'(k));
    end
    @(posedge sys_clk); #1;
    @(negedge sys_clk);
    check("burst_end_idle", fifo_wr_en === 1'b0);
    check("burst_frames", frame_cnt === 16'd4);
    @(posedge sys_clk); #1;

    // FIFO full for 5 cycles mid-stream
    s_data  = 16'h0100;
    s_valid = 1'b1;
    repeat (4) stream_cycle();
    fifo_full = 1'b1;
    acc_full  = 0;
    for (int i = 0; i < 5; i++) begin
      stream_cycle();
      if (took) acc_full++;
    end
    check("full_accepts_le2", acc_full <= 2);
    check("full_ready_low", s_ready === 1'b0);
    fifo_full = 1'b0;
    @(negedge sys_clk);
    check("full_resume", fifo_wr_en === 1'b1);
    took = s_valid && s_ready;
    @(posedge sys_clk); #1;
    if (took) s_data = s_data + 16'd1;
    repeat (6) stream_cycle();
    s_valid = 1'b0;
    repeat (4) tick();
    check("full_drained", sb.size() == 0);

    // Frame tagging: 12 words after a flush aligns the word counter
    enable = 1'b0;
    @(posedge sys_clk); #1;
    enable  = 1'b1;
    fc0     = frame_cnt;
    done0   = n_done;
    s_valid = 1'b1;
    s_data  = 16'h0200;
    acc = 0;
    cyc = 0;
    while (acc < 12 && cyc < 100) begin
      stream_cycle();
      if (took) acc++;
      cyc++;
    end
    s_valid = 1'b0;
    check("frame_accepts", acc == 12);
    repeat (4) tick();
    check("frame_cnt_delta", 16'(frame_cnt - fc0) === 16'd3);
    check("frame_pulses", (n_done - done0) == 3);

    // Flush with head + skid full
    s_valid = 1'b1;
    s_data  = 16'h0300;
    repeat (3) stream_cycle();
    fifo_full = 1'b1;
    repeat (4) stream_cycle();
    check("flush_pre_skid", dut.skid_valid === 1'b1);
    check("flush_pre_ready", s_ready === 1'b0);
    fc0     = frame_cnt;
    enable  = 1'b0;
    s_valid = 1'b0;
    @(negedge sys_clk);
    check("flush_wr_en", fifo_wr_en === 1'b0);
    @(posedge sys_clk); #1;
    check("flush_head", dut.head_valid === 1'b0);
    check("flush_skid", dut.skid_valid === 1'b0);
    check("flush_ready", s_ready === 1'b0);
    check("flush_word_cnt", dut.word_cnt === '0);
    fifo_full = 1'b0;
    @(posedge sys_clk); #1;
    enable  = 1'b1;
    s_valid = 1'b1;
    s_data  = 16'hA000;
    cyc = 0;
    do begin
      @(negedge sys_clk);
      cyc++;
    end while (!fifo_wr_en && cyc < 10);
    check("reen_wr_seen", fifo_wr_en === 1'b1);
    check("reen_first_data", fifo_wr_data === 16'hA000);
    check("reen_frame_cnt", frame_cnt === fc0);
    @(posedge sys_clk); #1;
    s_valid = 1'b0;
    repeat (4) tick();
    check("reen_drained", sb.size() == 0);

    // Random valid / full, 10k words
    acc = 0;
    cyc = 0;
    while (acc < 10000 && cyc < 60000) begin
      s_valid   = ($urandom_range(99) < 50);
      fifo_full = ($urandom_range(99) < 30);
      s_data    = 16'($urandom);
      tick();
      if (took) acc++;
      cyc++;
    end
    check("rand_words", acc == 10000);
    s_valid   = 1'b0;
    fifo_full = 1'b0;
    repeat (4) tick();
    check("rand_drained", sb.size() == 0);

    // Stall counter: head held under full for 7 cycles
    enable = 1'b0;
    @(posedge sys_clk); #1;
    enable    = 1'b1;
    fifo_full = 1'b1;
    @(posedge sys_clk); #1;
    s_valid = 1'b1;
    s_data  = 16'hB000;
    @(posedge sys_clk); #1;
    s_valid = 1'b0;
    st0     = stall_cycles;
    check("stall_head_valid", dut.head_valid === 1'b1);
    repeat (7) @(posedge sys_clk);
    #1;
`ifdef AXIS_IN_STALL_CNT_EN
    check("stall_delta", 32'(stall_cycles - st0) === 32'd7);
`else
    check("stall_zero", stall_cycles === 32'd0);
`endif
    fifo_full = 1'b0;
    repeat (3) tick();
    check("stall_drained", sb.size() == 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
